// File: rtl/test_stream_pkg.sv
// Shared types and constants for the Avalon-ST test source and its LFSR payload generator.
package test_stream_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAY,
        CSUM,
        GAP
    } state_t;

    localparam logic [15:0] HDR_MAGIC      = 16'hA5A5;
    localparam logic [31:0] LFSR_SEED      = 32'h0000_0001;
    // Right-shifting Galois mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_TAPS      = 32'h8020_0003;
    localparam int          BYTES_PER_BEAT = 4;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
    endfunction

endpackage

// File: rtl/test_source_v1_if.sv
// Avalon-ST stream bundle between the test source (master) and the capture-path test sink (slave).
interface test_source_v1_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             sop;
    logic             eop;
    logic [1:0]       empty;
    logic             ready;

    modport master (output data, valid, sop, eop, empty, input ready);
    modport slave  (input data, valid, sop, eop, empty, output ready);
endinterface

// File: rtl/lfsr32.sv
// Enable-stepped 32-bit Galois LFSR; resets asynchronously to the package seed.
module lfsr32
    import test_stream_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [31:0] value
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= LFSR_SEED;
        end else if (en) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/test_source_v1.sv
// Avalon-ST framed test-packet generator (header beat + payload pattern) feeding the test sink.
// Optional feature: define TEST_SOURCE_CSUM_EN to append an XOR checksum beat to every frame.
module test_source_v1
    import test_stream_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LEN_W   = 11,
    parameter int GAP_CYC = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             continuous,
    input  logic             mode,
    input  logic [LEN_W-1:0] frame_len,
    test_source_v1_if.master st,
    output logic             busy,
    output logic [15:0]      frame_cnt
);

    localparam int BEAT_W = LEN_W - 1;
    localparam int GAP_W  = $clog2(GAP_CYC + 1);
    localparam int BPB_SH = $clog2(BYTES_PER_BEAT);

`ifdef TEST_SOURCE_CSUM_EN
    localparam bit     CSUM_EN   = 1'b1;
    localparam state_t DATA_DONE = CSUM;
`else
    localparam bit     CSUM_EN   = 1'b0;
    localparam state_t DATA_DONE = GAP;
`endif

    state_t             state, state_nxt;
    logic               start_q;
    logic               start_edge;
    logic               xfer;
    logic               enter_hdr;
    logic [15:0]        seq;
    logic [15:0]        frame_seq;
    logic               mode_q;
    logic [BEAT_W-1:0]  beat;
    logic [BEAT_W-1:0]  last_beat;
    logic [1:0]         empty_q;
    logic [GAP_W-1:0]   gap_cnt;
    logic [LEN_W-1:0]   len_eff;
    logic [31:0]        lfsr_val;
    logic               lfsr_en;
    logic [WIDTH-1:0]   beat_data;

    assign start_edge = start & ~start_q;
    assign xfer       = st.valid & st.ready;
    assign enter_hdr  = (state_nxt == HDR) && (state != HDR);
    assign len_eff    = (frame_len < LEN_W'(BYTES_PER_BEAT)) ? LEN_W'(BYTES_PER_BEAT) : frame_len;
    assign lfsr_en    = xfer && (state == PAY) && mode_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        case (state)
            IDLE: if (start_edge) state_nxt = HDR;
            HDR:  if (xfer) state_nxt = (last_beat == '0) ? DATA_DONE : PAY;
            PAY:  if (xfer && (beat == last_beat)) state_nxt = DATA_DONE;
            CSUM: if (xfer) state_nxt = GAP;
            GAP:  if (gap_cnt == GAP_W'(GAP_CYC - 1)) state_nxt = continuous ? HDR : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame parameters are captured once on the way into HDR and hold for the whole frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state uses non-blocking assignments only.
            start_q   <= 1'b0;
            gap_cnt   <= '0;
            seq       <= '0;
            frame_seq <= '0;
            mode_q    <= 1'b0;
            last_beat <= '0;
            empty_q   <= '0;
            beat      <= '0;
            frame_cnt <= '0;
        end else begin
            start_q <= start;
            gap_cnt <= (state == GAP) ? gap_cnt + 1'b1 : '0;
            if (enter_hdr) begin
                frame_seq <= seq;
                mode_q    <= mode;
                last_beat <= BEAT_W'((len_eff - 1'b1) >> BPB_SH);
                empty_q   <= 2'd0 - len_eff[1:0];
                beat      <= '0;
            end else if (xfer) begin
                beat <= beat + 1'b1;
            end
            if (xfer && (state == HDR)) seq <= seq + 1'b1;
            if (xfer && st.eop) frame_cnt <= frame_cnt + 1'b1;
        end
    end

`ifdef TEST_SOURCE_CSUM_EN
    logic [WIDTH-1:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum <= '0;
        end else if (enter_hdr) begin
            csum <= '0;
        end else if (xfer) begin
            csum <= csum ^ st.data;
        end
    end
`endif

    lfsr32 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .value (lfsr_val)
    );

    // Outputs decode registered state only, so they stay put while the sink stalls.
    always_comb begin
        st.valid  = 1'b0;
        st.sop    = 1'b0;
        st.eop    = 1'b0;
        beat_data = '0;
        case (state)
            HDR: begin
                st.valid  = 1'b1;
                st.sop    = 1'b1;
                st.eop    = !CSUM_EN && (last_beat == '0);
                beat_data = {HDR_MAGIC, seq};
            end
            PAY: begin
                st.valid  = 1'b1;
                st.eop    = !CSUM_EN && (beat == last_beat);
                beat_data = mode_q ? lfsr_val : {frame_seq, 16'(beat)};
            end
`ifdef TEST_SOURCE_CSUM_EN
            CSUM: begin
                st.valid  = 1'b1;
                st.eop    = 1'b1;
                beat_data = csum;
            end
`endif
            default: ;
        endcase
    end

    assign st.data  = beat_data;
    assign st.empty = (st.eop && (state != CSUM)) ? empty_q : 2'd0;
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_test_source_v1.sv
// Self-checking bench for test_source_v1: frame-level expected-beat model plus directed scenarios.
module tb_test_source_v1;

    localparam int GAP_CYC = 4;
`ifdef TEST_SOURCE_CSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        continuous = 1'b0;
    logic        mode = 1'b0;
    logic [10:0] frame_len = '0;
    logic        busy;
    logic [15:0] frame_cnt;

    beat_t       exp_q[$];
    logic [15:0] m_seq;
    logic [31:0] m_lfsr;
    int          n_checks = 0;
    int          n_fail = 0;
    int          xfer_cnt = 0;
    int          sop_seen = 0;
    int          gap_run = 0;
    bit          after_eop = 1'b0;
    bit          chk_gap = 1'b0;

    test_source_v1_if #(.WIDTH(32)) st_if ();

    test_source_v1 #(.WIDTH(32), .LEN_W(11), .GAP_CYC(GAP_CYC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .continuous (continuous),
        .mode       (mode),
        .frame_len  (frame_len),
        .st         (st_if),
        .busy       (busy),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Polynomial x^32 + x^22 + x^2 + x + 1, one step per payload word.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    // Builds the complete expected beat list of one frame from its length and pattern.
    task automatic push_frame(input int len, input bit md);
        int          l;
        int          nb;
        logic [31:0] x;
        beat_t       b;
        l  = (len < 4) ? 4 : len;
        nb = (l + 3) / 4;
        x  = '0;
        for (int k = 0; k < nb; k++) begin
            if (k == 0) begin
                b.data = {16'hA5A5, m_seq};
            end else if (md) begin
                b.data = m_lfsr;
                m_lfsr = lfsr_next(m_lfsr);
            end else begin
                b.data = {m_seq, 16'(k)};
            end
            b.sop   = (k == 0);
            b.eop   = (k == nb - 1) && !CSUM_EN;
            b.empty = b.eop ? 2'((4 - l % 4) % 4) : 2'd0;
            x       = x ^ b.data;
            exp_q.push_back(b);
        end
        if (CSUM_EN) begin
            b.data  = x;
            b.sop   = 1'b0;
            b.eop   = 1'b1;
            b.empty = 2'd0;
            exp_q.push_back(b);
        end
        m_seq = m_seq + 16'd1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input string name);
        start = 1'b1;
        tick();
        check({name, "_latency_valid"}, st_if.valid, 1);
        check({name, "_latency_sop"}, st_if.sop, 1);
        start = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_drained"}, ok, 1);
    endtask

    // Compare process: every valid beat must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            after_eop = 1'b0;
            gap_run   = 0;
        end else if (st_if.valid) begin
            if (chk_gap && after_eop) check("gap_cycles", gap_run, GAP_CYC);
            after_eop = 1'b0;
            if (exp_q.size() == 0) begin
                check("spurious_valid", st_if.valid, 0);
            end else begin
                check("beat_data", st_if.data, exp_q[0].data);
                check("beat_flags", {st_if.sop, st_if.eop, st_if.empty},
                      {exp_q[0].sop, exp_q[0].eop, exp_q[0].empty});
                if (st_if.ready) begin
                    if (st_if.sop) sop_seen++;
                    if (st_if.eop && chk_gap) begin
                        after_eop = 1'b1;
                        gap_run   = 0;
                    end
                    xfer_cnt++;
                    void'(exp_q.pop_front());
                end
            end
        end else if (after_eop) begin
            gap_run++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int  x0;
        int  s0;
        bit  ok;
        m_seq        = '0;
        m_lfsr       = 32'h0000_0001;
        st_if.ready  = 1'b1;

        #12;
        check("rst_valid", st_if.valid, 0);
        check("rst_sop", st_if.sop, 0);
        check("rst_eop", st_if.eop, 0);
        check("rst_data", st_if.data, 0);
        check("rst_empty", st_if.empty, 0);
        check("rst_busy", busy, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 12-byte incrementing frame
        frame_len = 11'd12;
        mode      = 1'b0;
        push_frame(12, 1'b0);
        check("model_t1_beats", exp_q.size(), CSUM_EN ? 4 : 3);
        check("model_t1_b0", exp_q[0].data, 32'hA5A5_0000);
        check("model_t1_b1", exp_q[1].data, 32'h0000_0001);
        check("model_t1_b2", exp_q[2].data, 32'h0000_0002);
        launch("t1");
        check("t1_busy", busy, 1);
        wait_drain("t1");
        check("t1_frame_cnt", frame_cnt, 1);

        // 10 bytes: two unused bytes on the last data beat
        frame_len = 11'd10;
        push_frame(10, 1'b0);
        check("model_t2_b1", exp_q[1].data, 32'h0001_0001);
        check("model_t2_empty", exp_q[2].empty, CSUM_EN ? 0 : 2);
        launch("t2");
        wait_drain("t2");
        check("t2_frame_cnt", frame_cnt, 2);

        // 1 byte rounds up to a single header-only beat
        frame_len = 11'd1;
        push_frame(1, 1'b0);
        check("model_t3_beats", exp_q.size(), CSUM_EN ? 2 : 1);
        launch("t3");
        wait_drain("t3");
        check("t3_frame_cnt", frame_cnt, 3);

        // LFSR payload: first word is the seed, second is one step on
        mode      = 1'b1;
        frame_len = 11'd8;
        push_frame(8, 1'b1);
        check("model_t4_lfsr0", exp_q[1].data, 32'h0000_0001);
        if (CSUM_EN) check("model_t4_csum", exp_q[2].data, 32'hA5A5_0002);
        launch("t4a");
        wait_drain("t4a");
        frame_len = 11'd12;
        push_frame(12, 1'b1);
        check("model_t4_lfsr1", exp_q[1].data, 32'h8020_0003);
        launch("t4b");
        wait_drain("t4b");
        check("t4_frame_cnt", frame_cnt, 5);
        mode = 1'b0;

        // Backpressure every other cycle, with a start pulse while busy that must be ignored
        frame_len = 11'd16;
        push_frame(16, 1'b0);
        x0 = xfer_cnt;
        launch("t5");
        ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            st_if.ready = ~st_if.ready;
            if (i == 2) start = 1'b1;
            if (i == 4) start = 1'b0;
            tick();
            if (exp_q.size() == 0 && !busy) begin
                ok = 1'b1;
                break;
            end
        end
        st_if.ready = 1'b1;
        check("t5_drained", ok, 1);
        check("t5_transfers", xfer_cnt - x0, CSUM_EN ? 5 : 4);
        check("t5_frame_cnt", frame_cnt, 6);

        // Continuous frames, then drop continuous during the third frame
        frame_len = 11'd8;
        push_frame(8, 1'b0);
        push_frame(8, 1'b0);
        push_frame(8, 1'b0);
        chk_gap    = 1'b1;
        continuous = 1'b1;
        s0 = sop_seen;
        launch("t6");
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            tick();
            if (sop_seen >= s0 + 3) begin
                ok = 1'b1;
                break;
            end
        end
        continuous = 1'b0;
        check("t6_third_sop", ok, 1);
        wait_drain("t6");
        chk_gap = 1'b0;
        check("t6_frame_cnt", frame_cnt, 9);

        // Asynchronous reset in the middle of a payload
        frame_len = 11'd40;
        push_frame(40, 1'b0);
        launch("t7");
        tick();
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        check("t7_rst_valid", st_if.valid, 0);
        check("t7_rst_data", st_if.data, 0);
        check("t7_rst_flags", {st_if.sop, st_if.eop, st_if.empty}, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_frame_cnt", frame_cnt, 0);
        exp_q.delete();
        m_seq  = '0;
        m_lfsr = 32'h0000_0001;
        tick();
        rst_n = 1'b1;
        tick();
        frame_len = 11'd12;
        push_frame(12, 1'b0);
        check("model_t7_b0", exp_q[0].data, 32'hA5A5_0000);
        launch("t7");
        wait_drain("t7");
        check("t7_frame_cnt", frame_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
